adder_accum: RTL and testbench
==============================

Name: adder_accum

Overview:
- Consumer stage placed directly downstream of the 4-bit ripple adder (operands X, Y, carry-in Cin; outputs sum[3:0] and Cout).
- Takes each 5-bit adder result {Cout,sum} as an unsigned value over a valid/ready handshake.
- Accumulates COUNT results, or fewer if flushed early, into a wide register.
- Presents the total and beat count over an output valid/ready handshake, then clears for the next group.

Parameters:
- DATA_W, 4, width of the adder sum bus; the incoming value is DATA_W+1 bits wide.
- COUNT, 4, number of results per group; legal range 1..255.
- ACC_W, DATA_W+1+$clog2(COUNT) (derived, localparam), accumulator width; sized so the total cannot overflow (31*4=124 fits in 7 bits).
- CNT_W, $clog2(COUNT+1) (derived, localparam), width of the beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream result is valid.
- in_ready  out  1  block can accept a result this cycle.
- in_sum  in  DATA_W  adder sum.
- in_cout  in  1  adder carry-out; the accepted value is {in_cout,in_sum}.
- flush  in  1  close the current group early.
- out_valid  out  1  total is available.
- out_ready  in  1  downstream takes the total.
- out_acc  out  ACC_W  group total.
- out_cnt  out  CNT_W  number of results in the group.
- busy  out  1  cnt>0 or state==EMIT.

Behaviour:
- One clock and one reset: clk, with rst synchronous and active-high. All state is updated only on the rising edge of clk.
- Reset values: state=COLLECT, acc=0, cnt=0, out_valid=0, out_acc=0, out_cnt=0, busy=0.
  - in_ready is forced to 0 in any cycle where rst=1.
- rst asserted mid-group or mid-EMIT discards everything. There is no output pulse; out_valid is 0 on the next cycle.
- States:
  - COLLECT: in_ready=1 (combinational from state and rst).
  - EMIT: in_ready=0, out_valid=1.
- Accept: a transfer happens when in_valid&&in_ready. On that edge:
  - acc <= acc + zero-extended {in_cout,in_sum}.
  - cnt <= cnt+1.
- COLLECT -> EMIT happens on the edge where either of these holds:
  - an accept occurs with cnt==COUNT-1; or
  - flush=1 and (cnt>0 or an accept happens the same cycle).
- On that edge, out_acc and out_cnt load the post-accept values. Latency from the final accepted beat to out_valid=1 is 1 cycle.
- flush while cnt==0 with no accept: ignored. No empty groups are ever emitted.
- flush while in EMIT: ignored.
- flush and accept in the same cycle: the beat is included, then the block emits.
- EMIT: out_acc, out_cnt and out_valid are held stable until out_valid&&out_ready.
  - On that edge: acc<=0, cnt<=0, out_valid<=0, state<=COLLECT.
  - A new beat is accepted at the earliest 1 cycle after the handshake. There is no back-to-back overlap, so throughput is 1 group per COUNT+1 cycles minimum.
- out_ready has no effect while out_valid=0.
- in_sum and in_cout are don't-care while in_valid=0. X values on them must not propagate into acc.
- Arithmetic is unsigned only. acc cannot wrap for legal COUNT. An assertion checks acc <= (2**(DATA_W+1)-1)*COUNT.
- COUNT=1: every accepted beat goes straight to EMIT with out_cnt=1.

Decomposition:
- Shared package adder_pkg holds:
  - DATA_W default;
  - the state enum type (COLLECT, EMIT);
  - the function that computes ACC_W from DATA_W and COUNT, shared with the bench's reference model.
- No sub-module is needed. The adder itself stays a separate module and is instantiated next to this block at the top level, not inside it.

Test Plan:
- Full group: COUNT=4, feed {cout,sum} = 12, 31, 0, 17 (e.g. 7+5+0, 15+15+1, 0+0+0, 9+7+1) with out_ready=1. Expect out_valid 1 cycle after the 4th beat, out_acc=60, out_cnt=4, then in_ready=1 the cycle after the handshake.
- Backpressure: same stimulus with out_ready=0 for 5 cycles. out_acc=60 and out_cnt=4 must stay stable, in_ready=0 throughout, and in_valid pulses must be ignored. Release out_ready: exactly one transfer.
- Flush: 2 beats (10, 3), then flush alone. Expect out_acc=13, out_cnt=2. A flush with cnt=0 produces no out_valid.
- Simultaneous flush and beat: cnt=1 (acc=5), flush=1 with beat 8 in the same cycle. Expect out_acc=13, out_cnt=2.
- Reset mid-group: 3 beats, then rst for 1 cycle. Expect out_valid=0, busy=0, cnt=0. The next 4 beats of value 1 give out_acc=4.
- Random: 50 groups of random 4-bit a, b and 1-bit cin driven through adder -> adder_accum, with random out_ready and flush. Totals are compared against the reference model.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and width helpers for the ripple adder and its accumulating consumer.
package adder_pkg;

   localparam int DEF_DATA_W = 4;

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } acc_state_e;

   // Wide enough for COUNT maximal beats of DATA_W+1 bits, so the total never wraps.
   function automatic int acc_width(input int data_w, input int count);
      return data_w + 1 + $clog2(count);
   endfunction

   function automatic int cnt_width(input int count);
      return $clog2(count + 1);
   endfunction

endpackage

// File: rtl/adder_accum_if.sv
// Input beat handshake, flush, and total/count output handshake of adder_accum.
interface adder_accum_if #(
   parameter int DATA_W = adder_pkg::DEF_DATA_W,
   parameter int COUNT  = 4
);
   import adder_pkg::*;

   localparam int ACC_W = acc_width(DATA_W, COUNT);
   localparam int CNT_W = cnt_width(COUNT);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_sum;
   logic              in_cout;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]  out_cnt;
   logic              busy;

   modport master (
      output in_valid, in_sum, in_cout, flush, out_ready,
      input  in_ready, out_valid, out_acc, out_cnt, busy
   );

   modport slave (
      input  in_valid, in_sum, in_cout, flush, out_ready,
      output in_ready, out_valid, out_acc, out_cnt, busy
   );

endinterface

// File: rtl/adder.sv
// Parameterised ripple-carry adder: combinational, no handshake.
module adder #(
   parameter int W = adder_pkg::DEF_DATA_W
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   logic [W:0] carry;

   assign carry[0] = cin_i;

   for (genvar i = 0; i < W; i++) begin : g_bit
      logic p;
      assign p            = a_i[i] ^ b_i[i];
      assign sum_o[i]     = p ^ carry[i];
      assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & p);
   end

   assign cout_o = carry[W];

endmodule

// File: rtl/adder_accum.sv
// Sums COUNT adder results (or fewer on flush) and emits total+count 1 cycle after the last beat;
// total is held until out_ready, input is stalled while the total waits.
module adder_accum
   import adder_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int COUNT  = 4
) (
   input  logic          clk,
   input  logic          rst,
   adder_accum_if.slave  bus
);

   localparam int ACC_W = acc_width(DATA_W, COUNT);
   localparam int CNT_W = cnt_width(COUNT);
   localparam int unsigned ACC_MAX = ((2 ** (DATA_W + 1)) - 1) * COUNT;

   acc_state_e         state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_vld_q, out_vld_d;
   logic [ACC_W-1:0]   out_acc_q, out_acc_d;
   logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

   logic               accept;
   logic [DATA_W:0]    beat_val;
   logic [ACC_W-1:0]   acc_sum;
   logic [CNT_W-1:0]   cnt_sum;
   logic               close_grp;

   assign bus.in_ready = (state_q == COLLECT) && !rst;
   assign accept       = bus.in_valid && bus.in_ready;

   // Gate the operand so idle-cycle garbage on the adder outputs never reaches acc.
   assign beat_val  = accept ? {bus.in_cout, bus.in_sum} : '0;
   assign acc_sum   = acc_q + ACC_W'(beat_val);
   assign cnt_sum   = cnt_q + CNT_W'(accept);
   assign close_grp = (accept && (cnt_q == CNT_W'(COUNT - 1)))
                   || (bus.flush && ((cnt_q != '0) || accept));

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      out_vld_d = out_vld_q;
      out_acc_d = out_acc_q;
      out_cnt_d = out_cnt_q;
      case (state_q)
         COLLECT: begin
            acc_d = acc_sum;
            cnt_d = cnt_sum;
            if (close_grp) begin
               state_d   = EMIT;
               out_vld_d = 1'b1;
               out_acc_d = acc_sum;
               out_cnt_d = cnt_sum;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               state_d   = COLLECT;
               acc_d     = '0;
               cnt_d     = '0;
               out_vld_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= COLLECT;
         acc_q     <= '0;
         cnt_q     <= '0;
         out_vld_q <= 1'b0;
         out_acc_q <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         out_vld_q <= out_vld_d;
         out_acc_q <= out_acc_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (32'(acc_q) <= ACC_MAX);
      end
   end

   assign bus.out_valid = out_vld_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_cnt   = out_cnt_q;
   assign bus.busy      = (cnt_q != '0) || (state_q == EMIT);

endmodule

// File: tb/tb_adder_accum.sv
// Bench for adder -> adder_accum: directed scenarios plus randomized groups against a group-level model.
module tb_adder_accum;
   import adder_pkg::*;

   localparam int DW  = 4;
   localparam int CNT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a, b;
   logic       cin;

   always #5 clk = ~clk;

   adder_accum_if #(.DATA_W(DW), .COUNT(CNT)) bus ();

   adder #(.W(DW)) u_add (
      .a_i    (a),
      .b_i    (b),
      .cin_i  (cin),
      .sum_o  (bus.in_sum),
      .cout_o (bus.in_cout)
   );

   adder_accum #(.DATA_W(DW), .COUNT(CNT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Group-level model: running total and beat count, plus the pending group awaiting pickup.
   int  m_acc = 0, m_cnt = 0, m_oacc = 0, m_ocnt = 0, groups = 0;
   bit  m_emit = 0, m_live = 0;
   int  dut_hs = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_acc  = 0;
         m_cnt  = 0;
         m_emit = 0;
         m_live = 1;
      end else if (m_emit) begin
         if (bus.out_ready) begin
            m_emit = 0;
            m_acc  = 0;
            m_cnt  = 0;
            groups++;
         end
      end else begin
         if (bus.in_valid) begin
            m_acc += int'(a) + int'(b) + int'(cin);
            m_cnt++;
         end
         if ((bus.in_valid && m_cnt == CNT) || (bus.flush && m_cnt > 0)) begin
            m_emit = 1;
            m_oacc = m_acc;
            m_ocnt = m_cnt;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) dut_hs++;
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("in_ready", int'(bus.in_ready), int'(!rst && !m_emit));
         chk("out_valid", int'(bus.out_valid), int'(m_emit));
         chk("busy", int'(bus.busy), int'(m_cnt > 0 || m_emit));
         if (m_emit) begin
            chk("out_acc", int'(bus.out_acc), m_oacc);
            chk("out_cnt", int'(bus.out_cnt), m_ocnt);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Split a target value 0..31 into adder operands.
   task automatic set_val(input int v);
      int r;
      a   = 4'((v > 15) ? 15 : v);
      r   = v - int'(a);
      b   = 4'((r > 15) ? 15 : r);
      cin = 1'(r - int'(b));
   endtask

   task automatic beat(input int v);
      set_val(v);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int h0, g0, cyc;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0;

      repeat (2) step();
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_acc", int'(bus.out_acc), 0);
      chk("rst_out_cnt", int'(bus.out_cnt), 0);
      chk("rst_busy", int'(bus.busy), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", int'(bus.in_ready), 1);

      // Full group 12+31+0+17
      beat(12); beat(31); beat(0); beat(17);
      chk("full_out_valid", int'(bus.out_valid), 1);
      chk("full_out_acc", int'(bus.out_acc), 60);
      chk("full_out_cnt", int'(bus.out_cnt), 4);
      chk("full_in_ready_emit", int'(bus.in_ready), 0);
      step();
      chk("full_out_valid_clr", int'(bus.out_valid), 0);
      chk("full_in_ready_back", int'(bus.in_ready), 1);

      // Backpressure
      bus.out_ready = 1'b0;
      beat(12); beat(31); beat(0); beat(17);
      for (int i = 0; i < 5; i++) begin
         set_val($urandom_range(0, 31));
         bus.in_valid = 1'b1;
         step();
         chk("bp_out_acc", int'(bus.out_acc), 60);
         chk("bp_out_cnt", int'(bus.out_cnt), 4);
         chk("bp_in_ready", int'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      h0            = dut_hs;
      bus.out_ready = 1'b1;
      step();
      chk("bp_release_valid", int'(bus.out_valid), 0);
      step();
      chk("bp_one_transfer", dut_hs - h0, 1);
      chk("bp_busy_idle", int'(bus.busy), 0);

      // Early flush
      beat(10); beat(3);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("flush_out_valid", int'(bus.out_valid), 1);
      chk("flush_out_acc", int'(bus.out_acc), 13);
      chk("flush_out_cnt", int'(bus.out_cnt), 2);
      step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      step();
      chk("empty_flush_valid", int'(bus.out_valid), 0);
      chk("empty_flush_busy", int'(bus.busy), 0);

      // Flush together with a beat
      beat(5);
      set_val(8);
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      chk("simul_out_acc", int'(bus.out_acc), 13);
      chk("simul_out_cnt", int'(bus.out_cnt), 2);
      step();

      // Reset mid-group
      beat(7); beat(9); beat(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_out_cnt", int'(bus.out_cnt), 0);
      beat(1); beat(1); beat(1); beat(1);
      chk("midrst_out_acc", int'(bus.out_acc), 4);
      chk("midrst_grp_cnt", int'(bus.out_cnt), 4);
      step();

      // Randomized groups
      g0  = groups;
      cyc = 0;
      while (cyc < 5000 && (groups - g0) < 50) begin
         a             = 4'($urandom);
         b             = 4'($urandom);
         cin           = 1'($urandom);
         bus.in_valid  = ($urandom % 10) < 7;
         bus.flush     = ($urandom % 10) == 0;
         bus.out_ready = 1'($urandom);
         step();
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      chk("random_groups_done", int'((groups - g0) >= 50), 1);
      repeat (3) step();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
